// File: rtl/alu_req_arbiter.sv
// Round-robin front end that time-shares one combinational ALU among NUM_REQ
// requesters, registering operands toward the ALU and the result back out.
//
// state | meaning
// IDLE  | arbitrating; req_ready is one-hot to the round-robin winner
// EXEC  | operands registered to the ALU; result captured at end of cycle
// RESP  | response presented on rsp_*; held until rsp_ready
module alu_req_arbiter #(
    parameter  int NUM_REQ = 2,
    parameter  int WIDTH   = 8,
    parameter  int OP_W    = 3,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_op,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [OP_W-1:0]         alu_op,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    input  logic [WIDTH-1:0]        alu_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   rr_next;
    int                idx;

    // Walk offsets from the far end so the valid requester nearest to rr_ptr
    // is the last assignment and therefore wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        if (int'(rsp_id_q) + 1 >= NUM_REQ) begin
            rr_next = '0;
        end else begin
            rr_next = rsp_id_q + 1'b1;
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == IDLE) && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        alu_op_d   = alu_op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    alu_op_d = req_op[int'(grant_id) * OP_W +: OP_W];
                    alu_a_d  = req_a[int'(grant_id) * WIDTH +: WIDTH];
                    alu_b_d  = req_b[int'(grant_id) * WIDTH +: WIDTH];
                    rsp_id_d = grant_id;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = alu_result;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rr_ptr_d = rr_next;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

endmodule
